// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HBURST encodings, owner states
// and the burst-length helper used by the output-stage arbiters.
package ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic {
      OWN_IDLE  = 1'b0,
      OWN_OWNED = 1'b1
   } own_state_e;

   // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
         HBURST_WRAP16, HBURST_INCR16: return 4'd15;
         default:                      return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// Combinational round-robin picker: the first set request after last_owner
// (wrapping modulo NUM_IN) wins.
module ahb_mtx_rr_pick #(
   parameter int NUM_IN = 3
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [1:0]        last_owner,
   output logic [1:0]        winner,
   output logic              any_req
);

   logic [2:0] cand;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner  = 2'd0;
      any_req = 1'b0;
      cand    = 3'd0;
      for (int i = 1; i <= NUM_IN; i++) begin
         cand = {1'b0, last_owner} + 3'(i);
         if (cand >= 3'(NUM_IN)) cand = cand - 3'(NUM_IN);
         for (int n = 0; n < NUM_IN; n++) begin
            if (!any_req && req[n] && cand == 3'(n)) begin
               winner  = 2'(n);
               any_req = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ahb_mtx_out_arb.sv
// Bus-matrix output-stage arbiter: round-robin between input stages, holding
// the grant across fixed/undefined-length bursts and locked sequences.
module ahb_mtx_out_arb
   import ahb_mtx_pkg::*;
#(
   parameter int NUM_IN     = 3,
   parameter bit BURST_HOLD = 1'b1
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [NUM_IN-1:0]     req_in,
   input  logic [2*NUM_IN-1:0]   trans_in,
   input  logic [3*NUM_IN-1:0]   burst_in,
   input  logic [NUM_IN-1:0]     mastlock_in,
   input  logic                  HREADYM,
   output logic [1:0]            addr_in_port,
   output logic                  no_port,
   output logic [1:0]            data_in_port,
   output logic                  data_valid,
   output logic [NUM_IN-1:0]     active_out
);

   own_state_e        state_q, state_d;
   logic [1:0]        addr_q, addr_d;
   logic [1:0]        last_q, last_d;
   logic [1:0]        data_port_q, data_port_d;
   logic              data_valid_q, data_valid_d;
   logic [3:0]        beat_cnt_q, beat_cnt_d;
   logic [NUM_IN-1:0] active_q, active_d;

   logic [1:0]        trans_o;
   logic [2:0]        burst_o;
   logic              lock_o;
   logic [3:0]        beat_cnt_adv;
   logic              owned;
   logic              hold;
   logic [1:0]        winner;
   logic              any_req;

   ahb_mtx_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
      .req        (req_in),
      .last_owner (last_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Current owner's transfer attributes.
   always_comb begin
      trans_o = HTRANS_IDLE;
      burst_o = HBURST_SINGLE;
      lock_o  = 1'b0;
      for (int n = 0; n < NUM_IN; n++) begin
         if (addr_q == 2'(n)) begin
            trans_o = trans_in[2*n +: 2];
            burst_o = burst_in[3*n +: 3];
            lock_o  = mastlock_in[n];
         end
      end
   end

   assign owned = (state_q == OWN_OWNED);

   always_comb begin
      beat_cnt_adv = beat_cnt_q;
      if (owned) begin
         case (trans_o)
            HTRANS_NONSEQ: beat_cnt_adv = burst_beats(burst_o);
            HTRANS_SEQ:    beat_cnt_adv = (beat_cnt_q == 4'd0) ? 4'd0 : beat_cnt_q - 4'd1;
            default:       beat_cnt_adv = beat_cnt_q;
         endcase
      end
      hold = owned && (lock_o
                       || (BURST_HOLD && beat_cnt_adv != 4'd0)
                       || (BURST_HOLD && burst_o == HBURST_INCR && trans_o != HTRANS_IDLE));
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      last_d       = last_q;
      beat_cnt_d   = beat_cnt_q;
      data_port_d  = data_port_q;
      data_valid_d = data_valid_q;
      active_d     = active_q;

      if (HREADYM) begin
         data_port_d  = addr_q;
         data_valid_d = owned && (trans_o == HTRANS_NONSEQ || trans_o == HTRANS_SEQ);
         if (hold) begin
            beat_cnt_d = beat_cnt_adv;
         end else if (any_req) begin
            state_d    = OWN_OWNED;
            addr_d     = winner;
            last_d     = winner;
            beat_cnt_d = (owned && winner == addr_q) ? beat_cnt_adv : 4'd0;
         end else begin
            // Park on the previous owner so the address mux stays stable.
            state_d    = OWN_IDLE;
            beat_cnt_d = 4'd0;
         end
         for (int n = 0; n < NUM_IN; n++)
            active_d[n] = (state_d == OWN_OWNED) && (addr_d == 2'(n));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= OWN_IDLE;
         addr_q       <= 2'd0;
         last_q       <= 2'(NUM_IN - 1);
         beat_cnt_q   <= 4'd0;
         data_port_q  <= 2'd0;
         data_valid_q <= 1'b0;
         active_q     <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         last_q       <= last_d;
         beat_cnt_q   <= beat_cnt_d;
         data_port_q  <= data_port_d;
         data_valid_q <= data_valid_d;
         active_q     <= active_d;
      end
   end

   assign addr_in_port = addr_q;
   assign no_port      = (state_q == OWN_IDLE);
   assign data_in_port = data_port_q;
   assign data_valid   = data_valid_q;
   assign active_out   = active_q;

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// Directed bench for ahb_mtx_out_arb: rotation, burst/lock hold, wait states,
// idle parking and mid-burst reset, with hand-computed expectations.
module tb_ahb_mtx_out_arb;
   import ahb_mtx_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic [2:0] req_in;
   logic [5:0] trans_in;
   logic [8:0] burst_in;
   logic [2:0] mastlock_in;
   logic       HREADYM;
   logic [1:0] addr_in_port;
   logic       no_port;
   logic [1:0] data_in_port;
   logic       data_valid;
   logic [2:0] active_out;

   int checks = 0;
   int errors = 0;

   ahb_mtx_out_arb #(.NUM_IN(3), .BURST_HOLD(1'b1)) dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .req_in       (req_in),
      .trans_in     (trans_in),
      .burst_in     (burst_in),
      .mastlock_in  (mastlock_in),
      .HREADYM      (HREADYM),
      .addr_in_port (addr_in_port),
      .no_port      (no_port),
      .data_in_port (data_in_port),
      .data_valid   (data_valid),
      .active_out   (active_out)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input int n, input logic r, input logic [1:0] t,
                        input logic [2:0] b, input logic l);
      req_in[n]          = r;
      trans_in[2*n +: 2] = t;
      burst_in[3*n +: 3] = b;
      mastlock_in[n]     = l;
   endtask

   task automatic own(input string tag, input logic [1:0] a, input logic np, input logic [2:0] act);
      check({tag, "_addr"},   32'(addr_in_port), 32'(a));
      check({tag, "_noport"}, 32'(no_port),      32'(np));
      check({tag, "_active"}, 32'(active_out),   32'(act));
   endtask

   initial begin
      HRESET = 1'b1; HREADYM = 1'b1;
      req_in = '0; trans_in = '0; burst_in = '0; mastlock_in = '0;
      step(); step();
      HRESET = 1'b0;
      own("rst", 2'd0, 1'b1, 3'b000);
      check("rst_dport", 32'(data_in_port), 32'd0);
      check("rst_dvalid", 32'(data_valid), 32'd0);
      check("rst_beat", 32'(dut.beat_cnt_q), 32'd0);

      // 1: three SINGLE requesters rotate 0,1,2,0
      for (int n = 0; n < 3; n++) drive(n, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
      step(); own("rr0", 2'd0, 1'b0, 3'b001);
      check("rr0_dvalid", 32'(data_valid), 32'd0);
      step(); own("rr1", 2'd1, 1'b0, 3'b010);
      check("rr1_dvalid", 32'(data_valid), 32'd1);
      check("rr1_dport", 32'(data_in_port), 32'd0);
      step(); own("rr2", 2'd2, 1'b0, 3'b100);
      check("rr2_dport", 32'(data_in_port), 32'd1);
      step(); own("rr3", 2'd0, 1'b0, 3'b001);

      // 2: port 1 INCR4 while port 2 waits
      drive(0, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0);
      drive(1, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  1'b0);
      drive(2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
      step(); own("b4_grant", 2'd1, 1'b0, 3'b010);
      step(); check("b4_nseq_addr", 32'(addr_in_port), 32'd1);
      check("b4_nseq_beat", 32'(dut.beat_cnt_q), 32'd3);
      drive(1, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
      step(); check("b4_seq1_addr", 32'(addr_in_port), 32'd1);
      check("b4_seq1_beat", 32'(dut.beat_cnt_q), 32'd2);
      step(); check("b4_seq2_addr", 32'(addr_in_port), 32'd1);
      check("b4_seq2_beat", 32'(dut.beat_cnt_q), 32'd1);
      step(); own("b4_handoff", 2'd2, 1'b0, 3'b100);
      check("b4_handoff_beat", 32'(dut.beat_cnt_q), 32'd0);

      // 3: port 0 INCR4 with three wait states at beat 2
      drive(1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0);
      drive(2, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0);
      drive(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  1'b0);
      step(); own("ws_grant", 2'd0, 1'b0, 3'b001);
      step(); check("ws_nseq_beat", 32'(dut.beat_cnt_q), 32'd3);
      drive(0, 1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
      step(); check("ws_seq1_beat", 32'(dut.beat_cnt_q), 32'd2);
      HREADYM = 1'b0;
      drive(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
      for (int w = 0; w < 3; w++) begin
         step();
         check("ws_frz_beat",   32'(dut.beat_cnt_q), 32'd2);
         check("ws_frz_addr",   32'(addr_in_port),   32'd0);
         check("ws_frz_dvalid", 32'(data_valid),     32'd1);
      end
      HREADYM = 1'b1;
      drive(1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      step(); check("ws_seq2_beat", 32'(dut.beat_cnt_q), 32'd1);
      check("ws_seq2_addr", 32'(addr_in_port), 32'd0);
      step(); check("ws_seq3_beat", 32'(dut.beat_cnt_q), 32'd0);
      own("ws_done", 2'd0, 1'b0, 3'b001);

      // 4: port 2 locked over two SINGLEs with an IDLE between, port 0 waiting
      drive(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
      drive(2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      step(); own("lk_grant", 2'd2, 1'b0, 3'b100);
      step(); check("lk_t1_addr", 32'(addr_in_port), 32'd2);
      drive(2, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step(); check("lk_idle_addr", 32'(addr_in_port), 32'd2);
      check("lk_idle_dvalid", 32'(data_valid), 32'd0);
      drive(2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      step(); check("lk_t2_addr", 32'(addr_in_port), 32'd2);
      drive(2, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      step(); own("lk_release", 2'd0, 1'b0, 3'b001);

      // 5: all requests drop, owner 0 still presenting its last NONSEQ
      req_in = 3'b000;
      step(); own("idle1", 2'd0, 1'b1, 3'b000);
      check("idle1_dvalid", 32'(data_valid), 32'd1);
      drive(0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      step(); own("idle2", 2'd0, 1'b1, 3'b000);
      check("idle2_dvalid", 32'(data_valid), 32'd0);

      // 6: reset at beat 2 of an INCR8 on port 1
      drive(1, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 1'b0);
      step(); own("r8_grant", 2'd1, 1'b0, 3'b010);
      step(); check("r8_nseq_beat", 32'(dut.beat_cnt_q), 32'd7);
      drive(1, 1'b1, HTRANS_SEQ, HBURST_INCR8, 1'b0);
      step(); check("r8_seq1_beat", 32'(dut.beat_cnt_q), 32'd6);
      HRESET = 1'b1;
      drive(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
      step(); own("r8_rst", 2'd0, 1'b1, 3'b000);
      check("r8_rst_beat", 32'(dut.beat_cnt_q), 32'd0);
      HRESET = 1'b0;
      step(); own("r8_first", 2'd0, 1'b0, 3'b001);

      // 7: undefined-length INCR holds through BUSY, releases on IDLE
      drive(1, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0);
      step(); own("inc_grant", 2'd1, 1'b0, 3'b010);
      step(); check("inc_nseq_addr", 32'(addr_in_port), 32'd1);
      drive(1, 1'b1, HTRANS_BUSY, HBURST_INCR, 1'b0);
      step(); check("inc_busy_addr", 32'(addr_in_port), 32'd1);
      drive(1, 1'b0, HTRANS_IDLE, HBURST_INCR, 1'b0);
      step(); own("inc_release", 2'd0, 1'b0, 3'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
